// File: rtl/x2050add.sv
// Main adder stage of the 2050 data flow: binary/decimal sum into T with carry, overflow and zero latches.
// Optional byte parity on T is built when X2050_ADDER_PARITY_EN is defined.
module x2050add #(
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    input  logic [DW-1:0]     i_xin,
    input  logic [DW-1:0]     i_y,
    input  logic              i_tc,
    input  logic              i_dec,
    input  logic [1:0]        i_ci,
    input  logic              i_ld_t,
    input  logic              i_ld_c,
    output logic [DW-1:0]     o_sum,
    output logic [DW-1:0]     o_t,
    output logic              o_carry,
    output logic              o_ovf,
    output logic              o_zero,
    output logic [DW/8-1:0]   o_tp
);

    localparam int unsigned ND = DW / 4;
    localparam int unsigned NB = DW / 8;

    logic [DW-1:0] t_q;
    logic          carry_q;
    logic          ovf_q;
    logic          zero_q;

    logic          cin_c;
    logic [DW:0]   bin_full_c;
    logic          bin_cmsb_c;
    logic [DW-1:0] dec_l_c;
    logic [DW-1:0] dec_sum_c;
    logic          dec_co_c;
    logic          dec_cy_c;
    logic [4:0]    dig_c;
    logic          co_c;
    logic          ovf_calc_c;

    // Carry-in select; the latch term is the value held before this edge
    always_comb begin
        cin_c = 1'b0;
        case (i_ci)
            2'd0:    cin_c = 1'b0;
            2'd1:    cin_c = 1'b1;
            2'd2:    cin_c = carry_q;
            default: cin_c = ~carry_q;
        endcase
    end

    assign bin_full_c = {1'b0, i_xin} + {1'b0, i_y} + (DW+1)'(cin_c);
    assign bin_cmsb_c = bin_full_c[DW-1] ^ i_xin[DW-1] ^ i_y[DW-1];

    // True decimal add pre-biases each digit by 6 so digit carries occur at 10
    assign dec_l_c = i_xin + (i_tc ? {ND{4'h6}} : DW'(0));

    // Ripple by digit; digits without carry-out drop the bias locally
    always_comb begin
        dec_sum_c = '0;
        dec_cy_c  = cin_c;
        dig_c     = '0;
        for (int k = 0; k < int'(ND); k++) begin
            dig_c    = 5'(dec_l_c[4*k +: 4]) + 5'(i_y[4*k +: 4]) + 5'(dec_cy_c);
            dec_cy_c = dig_c[4];
            dec_sum_c[4*k +: 4] = dig_c[4] ? dig_c[3:0] : (dig_c[3:0] - 4'd6);
        end
        dec_co_c = dec_cy_c;
    end

    assign o_sum      = i_dec ? dec_sum_c : bin_full_c[DW-1:0];
    assign co_c       = i_dec ? dec_co_c  : bin_full_c[DW];
    assign ovf_calc_c = i_dec ? 1'b0      : (bin_cmsb_c ^ bin_full_c[DW]);

    // T and condition latches; loads are independent and gated by i_advance
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else if (i_advance) begin
            if (i_ld_t) begin
                t_q    <= o_sum;
                zero_q <= (o_sum == '0);
            end
            if (i_ld_c) begin
                carry_q <= co_c;
                ovf_q   <= ovf_calc_c;
            end
        end
    end

    assign o_t     = t_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

`ifdef X2050_ADDER_PARITY_EN
    logic [NB-1:0] tp_q;
    logic [NB-1:0] tp_next_c;

    always_comb begin
        tp_next_c = '1;
        for (int k = 0; k < int'(NB); k++) begin
            tp_next_c[k] = ~^o_sum[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q <= '1;
        end else if (i_advance && i_ld_t) begin
            tp_q <= tp_next_c;
        end
    end

    assign o_tp = tp_q;
`else
    assign o_tp = {NB{1'b1}};
`endif

endmodule

// File: tb/tb_x2050add.sv
// Scoreboarded directed/random bench for x2050add; parity expectations follow X2050_ADDER_PARITY_EN.
module tb_x2050add;

    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_advance;
    logic [DW-1:0]   i_xin;
    logic [DW-1:0]   i_y;
    logic            i_tc;
    logic            i_dec;
    logic [1:0]      i_ci;
    logic            i_ld_t;
    logic            i_ld_c;
    logic [DW-1:0]   o_sum;
    logic [DW-1:0]   o_t;
    logic            o_carry;
    logic            o_ovf;
    logic            o_zero;
    logic [DW/8-1:0] o_tp;

    x2050add #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .i_advance(i_advance), .i_xin(i_xin), .i_y(i_y),
        .i_tc(i_tc), .i_dec(i_dec), .i_ci(i_ci), .i_ld_t(i_ld_t), .i_ld_c(i_ld_c),
        .o_sum(o_sum), .o_t(o_t), .o_carry(o_carry), .o_ovf(o_ovf),
        .o_zero(o_zero), .o_tp(o_tp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic        c;
        logic        ovf;
        logic        zero;
        logic [3:0]  tp;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_t;
    logic        m_c, m_ovf, m_zero;
    logic [3:0]  m_tp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] par_ref(input logic [31:0] v);
        logic [3:0] p;
`ifdef X2050_ADDER_PARITY_EN
        for (int b = 0; b < 4; b++) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(v[8*b+i]);
            p[b] = (ones % 2 == 0);
        end
`else
        p = 4'hf;
        if (v == 32'h0) p = 4'hf;
`endif
        return p;
    endfunction

    // Returns {ovf, co, sum}
    function automatic logic [33:0] add_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic tc, input logic dec, input logic cin);
        logic [32:0] s;
        logic [31:0] l, r;
        logic [4:0]  d;
        logic        c, ov;
        if (!dec) begin
            s  = 33'(x) + 33'(y) + 33'(cin);
            ov = (x[31] == y[31]) && (s[31] != x[31]);
            return {ov, s};
        end
        l = x + (tc ? 32'h66666666 : 32'h0);
        c = cin;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            d = 5'(l[4*k +: 4]) + 5'(y[4*k +: 4]) + 5'(c);
            c = d[4];
            r[4*k +: 4] = c ? d[3:0] : d[3:0] + 4'd10;
        end
        return {1'b0, c, r};
    endfunction

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1; i_advance = 1'b1; i_ld_t = 1'b1; i_ld_c = 1'b1;
        i_xin = 32'h1234; i_y = 32'h1; i_ci = 2'd1; i_dec = 1'b0; i_tc = 1'b1;
        m_t = '0; m_c = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_tp = 4'hf;
        e = '{t: m_t, c: m_c, ovf: m_ovf, zero: m_zero, tp: m_tp};
        sb.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
        compare("rst");
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".t"},    64'(o_t),     64'(e.t));
        chk({tag, ".c"},    64'(o_carry), 64'(e.c));
        chk({tag, ".ovf"},  64'(o_ovf),   64'(e.ovf));
        chk({tag, ".zero"}, 64'(o_zero),  64'(e.zero));
        chk({tag, ".tp"},   64'(o_tp),    64'(e.tp));
    endtask

    task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic tc, input logic dec, input logic [1:0] ci,
                        input logic ld_t, input logic ld_c, input logic adv,
                        input logic use_const, input logic [31:0] c_sum);
        logic [33:0] r;
        logic        cin;
        exp_t        e;
        @(negedge clk);
        i_xin = x; i_y = y; i_tc = tc; i_dec = dec; i_ci = ci;
        i_ld_t = ld_t; i_ld_c = ld_c; i_advance = adv;
        case (ci)
            2'd0: cin = 1'b0;
            2'd1: cin = 1'b1;
            2'd2: cin = m_c;
            default: cin = ~m_c;
        endcase
        r = add_ref(x, y, tc, dec, cin);
        #1;
        chk({tag, ".sum"}, 64'(o_sum), 64'(r[31:0]));
        if (use_const) chk({tag, ".sumk"}, 64'(o_sum), 64'(c_sum));
        if (adv && ld_t) begin
            m_t = r[31:0]; m_zero = (r[31:0] == 32'h0); m_tp = par_ref(r[31:0]);
        end
        if (adv && ld_c) begin
            m_c = r[32]; m_ovf = r[33];
        end
        e = '{t: m_t, c: m_c, ovf: m_ovf, zero: m_zero, tp: m_tp};
        sb.push_back(e);
        @(posedge clk); #1;
        compare(tag);
    endtask

    initial begin
        rst = 1'b1; i_advance = 1'b0; i_xin = '0; i_y = '0; i_tc = 1'b1;
        i_dec = 1'b0; i_ci = 2'd0; i_ld_t = 1'b0; i_ld_c = 1'b0;
        m_t = '0; m_c = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_tp = 4'hf;

        do_reset();
        chk("rst.tp_const", 64'(o_tp), 64'(4'hf));

        step("bin_ovf", 32'h7fffffff, 32'h1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80000000);
        chk("bin_ovf.t_const", 64'(o_t), 64'(32'h80000000));
        chk("bin_ovf.ovf_const", 64'(o_ovf), 64'(1'b1));

        step("bin_wrap", 32'hffffffff, 32'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        step("cin_latch", 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1);
        chk("cin_latch.c_const", 64'(o_carry), 64'(1'b1));
        step("cin_inv", 32'h5, 32'h6, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hb);

        step("dec_true", 32'h19, 32'h3, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22);
        chk("dec_true.c_const", 64'(o_carry), 64'(1'b0));
        step("dec_comp", 32'hfffffff8, 32'h25, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h18);
        chk("dec_comp.c_const", 64'(o_carry), 64'(1'b1));
        step("dec_full", 32'h99999999, 32'h1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);

        step("hold", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step("zero_t", 32'hffffffff, 32'h1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);

        step("par_ff", 32'hff, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hff);
`ifdef X2050_ADDER_PARITY_EN
        chk("par_ff.tp_const", 64'(o_tp), 64'(4'b1111));
`endif
        step("par_01", 32'h1, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1);
`ifdef X2050_ADDER_PARITY_EN
        chk("par_01.tp_const", 64'(o_tp), 64'(4'b1110));
`endif

        // Set carry, then reset mid-run: carry-in from latch must be 0
        step("pre_rst", 32'hffffffff, 32'h2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        do_reset();
        step("post_rst", 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);

        for (int n = 0; n < 40; n++) begin
            step("rnd", $urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
